// File: rtl/amba_id_tagger_if.sv
`default_nettype none
// ============================================================================
//  Module   : amba_id_tagger_if
//  Purpose  : Bundles the upstream request/response ports of all masters, the
//             shared downstream request/response channel pair and the status
//             outputs of the AMBA request-ID tagger.
//  Modports : slave  - seen by the tagger (takes master requests, drives the
//                      downstream request and the upstream responses)
//             master - seen by the environment (masters + crossbar side)
//  Revision : 1.0  initial release
// ============================================================================
interface amba_id_tagger_if #(
    parameter int NMST  = 4,
    parameter int LID_W = 4,
    parameter int PID_W = 4,
    parameter int AW    = 32,
    parameter int DW    = 64
);
    // upstream requests
    logic [NMST-1:0]        m_req_valid;
    logic [NMST-1:0]        m_req_ready;
    logic [NMST*LID_W-1:0]  m_req_id;
    logic [NMST*AW-1:0]     m_req_addr;
    // downstream request
    logic                   s_req_valid;
    logic                   s_req_ready;
    logic [PID_W+LID_W-1:0] s_req_id;
    logic [AW-1:0]          s_req_addr;
    // downstream response
    logic                   s_rsp_valid;
    logic                   s_rsp_ready;
    logic [PID_W+LID_W-1:0] s_rsp_id;
    logic [DW-1:0]          s_rsp_data;
    logic                   s_rsp_last;
    // upstream responses
    logic [NMST-1:0]        m_rsp_valid;
    logic [NMST-1:0]        m_rsp_ready;
    logic [LID_W-1:0]       m_rsp_id;
    logic [DW-1:0]          m_rsp_data;
    logic                   m_rsp_last;
    // status
    logic                   err_unmapped;
    logic                   idle;

    modport slave (
        input  m_req_valid, m_req_id, m_req_addr,
        output m_req_ready,
        output s_req_valid, s_req_id, s_req_addr,
        input  s_req_ready,
        input  s_rsp_valid, s_rsp_id, s_rsp_data, s_rsp_last,
        output s_rsp_ready,
        output m_rsp_valid, m_rsp_id, m_rsp_data, m_rsp_last,
        input  m_rsp_ready,
        output err_unmapped, idle
    );

    modport master (
        output m_req_valid, m_req_id, m_req_addr,
        input  m_req_ready,
        input  s_req_valid, s_req_id, s_req_addr,
        output s_req_ready,
        output s_rsp_valid, s_rsp_id, s_rsp_data, s_rsp_last,
        input  s_rsp_ready,
        input  m_rsp_valid, m_rsp_id, m_rsp_data, m_rsp_last,
        output m_rsp_ready,
        input  err_unmapped, idle
    );
endinterface
`default_nettype wire

// File: rtl/amba_id_tagger.sv
`default_nettype none
// ============================================================================
//  Module   : amba_id_tagger
//  Purpose  : Merges NMST upstream request streams onto one downstream channel.
//             Each request ID is extended with the master's AMBAID prefix,
//             masters are served round-robin, outstanding requests are capped
//             per master, and responses are routed back by prefix.
//  Ports    : aclk    - clock
//             aresetn - asynchronous active-low reset
//             bus     - amba_id_tagger_if.slave (request/response channels,
//                       err_unmapped pulse, idle status)
//  Revision : 1.0  initial release
// ============================================================================
module amba_id_tagger #(
    parameter int                        NMST      = 4,
    parameter int                        LID_W     = 4,
    parameter int                        PID_W     = 4,
    parameter int                        AW        = 32,
    parameter int                        DW        = 64,
    parameter int                        MAX_OUTST = 8,
    parameter logic [NMST*PID_W-1:0]     MST_PID   = {4'h7, 4'h5, 4'h4, 4'h3}
) (
    input  wire logic         aclk,
    input  wire logic         aresetn,
    amba_id_tagger_if.slave   bus
);

    localparam int                PTR_W = (NMST > 1) ? $clog2(NMST) : 1;
    localparam int                CNT_W = 8;
    localparam int                SID_W = PID_W + LID_W;
    localparam logic [CNT_W-1:0]  C_MAX = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0]  C_LAST_MST = PTR_W'(NMST - 1);

    // holding register feeding the downstream request channel
    logic                 r_hold_valid;
    logic [SID_W-1:0]     r_hold_id;
    logic [AW-1:0]        r_hold_addr;
    logic [PTR_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_cnt [NMST];
    logic                 r_err;

    logic [NMST-1:0]      w_elig;
    logic [NMST-1:0]      w_match;
    logic [NMST-1:0]      w_inc;
    logic [NMST-1:0]      w_dec;
    logic [NMST-1:0]      w_cnt_nz;
    logic [NMST-1:0]      w_req_ready;
    logic                 w_can_load;
    logic                 w_gnt_vld;
    logic [PTR_W-1:0]     w_gnt_idx;
    logic                 w_mapped;
    logic [PID_W-1:0]     w_rsp_pid;

    assign w_rsp_pid  = bus.s_rsp_id[SID_W-1 -: PID_W];
    // a new request may enter only if the holding slot is free or leaves now
    assign w_can_load = !r_hold_valid || bus.s_req_ready;

    for (genvar gi = 0; gi < NMST; gi++) begin : g_mst
        assign w_elig[gi]   = bus.m_req_valid[gi] && (r_cnt[gi] < C_MAX);
        assign w_match[gi]  = (w_rsp_pid == MST_PID[gi*PID_W +: PID_W]);
        assign w_inc[gi]    = w_gnt_vld && (w_gnt_idx == PTR_W'(gi));
        // only the last beat of an accepted response retires a transaction
        assign w_dec[gi]    = bus.s_rsp_valid && w_match[gi] &&
                              bus.m_rsp_ready[gi] && bus.s_rsp_last;
        assign w_cnt_nz[gi] = (r_cnt[gi] != '0);
    end

    // round-robin search starting at r_ptr; first eligible master wins
    always_comb begin
        int idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        idx       = 0;
        for (int k = 0; k < NMST; k++) begin
            idx = (int'(r_ptr) + k) % NMST;
            if (!w_gnt_vld && w_can_load && w_elig[PTR_W'(idx)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (w_gnt_vld) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign bus.m_req_ready = w_req_ready;
    assign bus.s_req_valid = r_hold_valid;
    assign bus.s_req_id    = r_hold_id;
    assign bus.s_req_addr  = r_hold_addr;

    // response path is purely combinational; unmapped beats are sunk
    assign w_mapped         = |w_match;
    assign bus.m_rsp_valid  = bus.s_rsp_valid ? w_match : '0;
    assign bus.s_rsp_ready  = w_mapped ? |(w_match & bus.m_rsp_ready) : 1'b1;
    assign bus.m_rsp_id     = bus.s_rsp_id[LID_W-1:0];
    assign bus.m_rsp_data   = bus.s_rsp_data;
    assign bus.m_rsp_last   = bus.s_rsp_last;
    assign bus.err_unmapped = r_err;
    assign bus.idle         = !r_hold_valid && !(|w_cnt_nz);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hold_valid <= 1'b0;
            r_hold_id    <= '0;
            r_hold_addr  <= '0;
            r_ptr        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= bus.s_rsp_valid && !w_mapped;
            if (w_gnt_vld) begin
                r_hold_valid <= 1'b1;
                r_hold_id    <= {MST_PID[w_gnt_idx*PID_W +: PID_W],
                                 bus.m_req_id[w_gnt_idx*LID_W +: LID_W]};
                r_hold_addr  <= bus.m_req_addr[w_gnt_idx*AW +: AW];
                r_ptr        <= (w_gnt_idx == C_LAST_MST) ? '0 : w_gnt_idx + 1'b1;
            end else if (bus.s_req_ready) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // outstanding counters; simultaneous +1/-1 cancel, -1 at zero saturates
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NMST; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NMST; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i] && w_cnt_nz[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_amba_id_tagger.sv
`default_nettype none
// ============================================================================
//  Module   : tb_amba_id_tagger
//  Purpose  : Self-checking bench for amba_id_tagger. Requests accepted
//             upstream are queued with their expected tagged ID/address and
//             compared when they leave on the downstream channel; each
//             scenario task checks its own responses, counters and status.
//  Revision : 1.0  initial release
// ============================================================================
module tb_amba_id_tagger;

    localparam int NMST = 4;
    localparam int LID_W = 4;
    localparam int PID_W = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MAX_OUTST = 8;
    localparam logic [15:0] C_PID = 16'h7543;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          errors;
    int          checks;
    int          gcount [NMST];
    logic [31:0] maddr  [NMST];
    exp_t        q [$];

    amba_id_tagger_if #(.NMST(NMST), .LID_W(LID_W), .PID_W(PID_W), .AW(AW), .DW(DW)) bus ();

    amba_id_tagger #(
        .NMST(NMST), .LID_W(LID_W), .PID_W(PID_W), .AW(AW), .DW(DW),
        .MAX_OUTST(MAX_OUTST), .MST_PID(C_PID)
    ) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pid_of(input int i);
        logic [15:0] t;
        t = C_PID;
        return t[i*4 +: 4];
    endfunction

    // Scoreboard step: record accepted requests, compare issued ones,
    // then advance one clock and move granted masters to a fresh address.
    task automatic sb_cycle();
        logic [NMST-1:0] g;
        exp_t e;
        #1;
        g = bus.m_req_valid & bus.m_req_ready;
        for (int i = 0; i < NMST; i++) begin
            if (g[i]) begin
                e.id   = {pid_of(i), bus.m_req_id[i*LID_W +: LID_W]};
                e.addr = maddr[i];
                q.push_back(e);
                gcount[i]++;
            end
        end
        if (bus.s_req_valid && bus.s_req_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_req: unexpected request id=%h addr=%h, nothing expected",
                         bus.s_req_id, bus.s_req_addr);
            end else begin
                e = q.pop_front();
                if (bus.s_req_id !== e.id || bus.s_req_addr !== e.addr) begin
                    errors++;
                    $display("FAIL sb_req: got id=%h addr=%h want id=%h addr=%h",
                             bus.s_req_id, bus.s_req_addr, e.id, e.addr);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NMST; i++) begin
            if (g[i]) begin
                maddr[i] = maddr[i] + 32'h10;
                bus.m_req_addr[i*AW +: AW] = maddr[i];
            end
        end
    endtask

    task automatic clear_inputs();
        bus.m_req_valid = '0;
        bus.m_req_id    = '0;
        bus.s_req_ready = 1'b0;
        bus.s_rsp_valid = 1'b0;
        bus.s_rsp_id    = '0;
        bus.s_rsp_data  = '0;
        bus.s_rsp_last  = 1'b0;
        bus.m_rsp_ready = '0;
    endtask

    task automatic clear_rsp();
        bus.s_rsp_valid = 1'b0;
        bus.s_rsp_last  = 1'b0;
        bus.m_rsp_ready = '0;
    endtask

    task automatic set_req(input logic [3:0] vld, input logic [3:0] id);
        bus.m_req_valid = vld;
        for (int i = 0; i < NMST; i++) bus.m_req_id[i*LID_W +: LID_W] = id;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < NMST; i++) begin
            gcount[i] = 0;
            maddr[i]  = 32'h1000_0000 * (i + 1);
            bus.m_req_addr[i*AW +: AW] = maddr[i];
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.s_req_valid !== 1'b0 || bus.idle !== 1'b1 || bus.err_unmapped !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got s_req_valid=%b idle=%b err=%b want 0 1 0",
                     bus.s_req_valid, bus.idle, bus.err_unmapped);
        end
        do_reset();
        #1;
        checks++;
        if (dut.r_cnt[0] !== 8'd0 || dut.r_cnt[1] !== 8'd0 ||
            dut.r_cnt[2] !== 8'd0 || dut.r_cnt[3] !== 8'd0 || bus.m_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_counters: got cnt=%0d,%0d,%0d,%0d ready=%b want all 0",
                     dut.r_cnt[0], dut.r_cnt[1], dut.r_cnt[2], dut.r_cnt[3], bus.m_req_ready);
        end
        sb_cycle();
    endtask

    task automatic test_round_robin();
        logic [7:0] want;
        do_reset();
        set_req(4'hF, 4'h1);
        bus.s_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (bus.m_req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.m_req_ready, 4'(1 << (k % 4)));
            end
            checks++;
            if (k == 0) begin
                if (bus.s_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_latency: got s_req_valid=%b want 0", bus.s_req_valid);
                end
            end else begin
                want = {pid_of((k - 1) % 4), 4'h1};
                if (bus.s_req_valid !== 1'b1 || bus.s_req_id !== want) begin
                    errors++;
                    $display("FAIL rr_id[%0d]: got v=%b id=%h want v=1 id=%h",
                             k, bus.s_req_valid, bus.s_req_id, want);
                end
            end
            sb_cycle();
        end
        bus.m_req_valid = '0;
        #1;
        checks++;
        if (bus.s_req_valid !== 1'b1 || bus.s_req_id !== 8'h71) begin
            errors++;
            $display("FAIL rr_last_id: got v=%b id=%h want v=1 id=71", bus.s_req_valid, bus.s_req_id);
        end
        sb_cycle();
        #1;
        checks++;
        if (bus.s_req_valid !== 1'b0 || bus.idle !== 1'b0 || dut.r_cnt[0] !== 8'd2 ||
            dut.r_cnt[1] !== 8'd2 || dut.r_cnt[2] !== 8'd2 || dut.r_cnt[3] !== 8'd2) begin
            errors++;
            $display("FAIL rr_counts: got v=%b idle=%b cnt=%0d,%0d,%0d,%0d want 0 0 2,2,2,2",
                     bus.s_req_valid, bus.idle, dut.r_cnt[0], dut.r_cnt[1], dut.r_cnt[2], dut.r_cnt[3]);
        end
        sb_cycle();
    endtask

    task automatic test_throttle();
        int base;
        do_reset();
        set_req(4'b0001, 4'h5);
        bus.s_req_ready = 1'b1;
        repeat (12) sb_cycle();
        #1;
        checks++;
        if (gcount[0] !== 8 || bus.m_req_ready !== 4'b0000 || dut.r_cnt[0] !== 8'd8) begin
            errors++;
            $display("FAIL throttle_cap: got grants=%0d ready=%b cnt=%0d want 8 0000 8",
                     gcount[0], bus.m_req_ready, dut.r_cnt[0]);
        end
        bus.s_rsp_valid = 1'b1;
        bus.s_rsp_id    = 8'h35;
        bus.s_rsp_data  = 64'h1234;
        bus.s_rsp_last  = 1'b1;
        bus.m_rsp_ready = 4'b0001;
        #1;
        checks++;
        if (bus.m_rsp_valid !== 4'b0001 || bus.s_rsp_ready !== 1'b1 || bus.m_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL throttle_rsp: got rsp_valid=%b s_rsp_ready=%b req_ready=%b want 0001 1 0000",
                     bus.m_rsp_valid, bus.s_rsp_ready, bus.m_req_ready);
        end
        sb_cycle();
        clear_rsp();
        #1;
        checks++;
        if (bus.m_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL throttle_reopen: got ready=%b want 0001", bus.m_req_ready);
        end
        base = gcount[0];
        repeat (5) sb_cycle();
        #1;
        checks++;
        if (gcount[0] - base !== 1 || bus.m_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL throttle_regrant: got grants=%0d ready=%b want 1 0000",
                     gcount[0] - base, bus.m_req_ready);
        end
        bus.m_req_valid = '0;
        sb_cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] held_addr;
        do_reset();
        bus.m_req_id    = 16'h0BA0;
        bus.m_req_valid = 4'b0110;
        bus.s_req_ready = 1'b0;
        #1;
        checks++;
        if (bus.m_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first_grant: got %b want 0010", bus.m_req_ready);
        end
        held_addr = maddr[1];
        sb_cycle();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus.m_req_ready !== 4'b0000 || bus.s_req_valid !== 1'b1 ||
                bus.s_req_id !== 8'h4A || bus.s_req_addr !== held_addr) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ready=%b v=%b id=%h addr=%h want 0000 1 4a %h",
                         k, bus.m_req_ready, bus.s_req_valid, bus.s_req_id, bus.s_req_addr, held_addr);
            end
            sb_cycle();
        end
        bus.s_req_ready = 1'b1;
        #1;
        checks++;
        if (bus.m_req_ready !== 4'b0100 || bus.s_req_id !== 8'h4A) begin
            errors++;
            $display("FAIL bp_release: got ready=%b id=%h want 0100 4a", bus.m_req_ready, bus.s_req_id);
        end
        sb_cycle();
        bus.m_req_valid = '0;
        #1;
        checks++;
        if (bus.s_req_valid !== 1'b1 || bus.s_req_id !== 8'h5B) begin
            errors++;
            $display("FAIL bp_next: got v=%b id=%h want 1 5b", bus.s_req_valid, bus.s_req_id);
        end
        sb_cycle();
        sb_cycle();
    endtask

    task automatic test_rsp_burst();
        int          beat_of [5];
        logic [3:0]  rdy_of  [5];
        logic [63:0] want_data;
        beat_of = '{0, 1, 1, 2, 3};
        rdy_of  = '{4'b0100, 4'b1011, 4'b0100, 4'b0100, 4'b0100};
        do_reset();
        set_req(4'b0100, 4'h2);
        bus.s_req_ready = 1'b1;
        sb_cycle();
        sb_cycle();
        bus.m_req_valid = '0;
        sb_cycle();
        sb_cycle();
        for (int s = 0; s < 5; s++) begin
            want_data       = 64'hD00D_0000_0000_0000 + 64'(beat_of[s]);
            bus.s_rsp_valid = 1'b1;
            bus.s_rsp_id    = 8'h52;
            bus.s_rsp_data  = want_data;
            bus.s_rsp_last  = (beat_of[s] == 3);
            bus.m_rsp_ready = rdy_of[s];
            #1;
            checks++;
            if (bus.m_rsp_valid !== 4'b0100 || bus.m_rsp_id !== 4'h2 || bus.m_rsp_data !== want_data ||
                bus.m_rsp_last !== (beat_of[s] == 3) || bus.s_rsp_ready !== rdy_of[s][2]) begin
                errors++;
                $display("FAIL burst_route[%0d]: got valid=%b id=%h data=%h last=%b ready=%b want 0100 2 %h %b %b",
                         s, bus.m_rsp_valid, bus.m_rsp_id, bus.m_rsp_data, bus.m_rsp_last,
                         bus.s_rsp_ready, want_data, (beat_of[s] == 3), rdy_of[s][2]);
            end
            checks++;
            if (dut.r_cnt[2] !== 8'd2) begin
                errors++;
                $display("FAIL burst_cnt_hold[%0d]: got %0d want 2", s, dut.r_cnt[2]);
            end
            sb_cycle();
        end
        clear_rsp();
        #1;
        checks++;
        if (dut.r_cnt[2] !== 8'd1) begin
            errors++;
            $display("FAIL burst_cnt_dec: got %0d want 1", dut.r_cnt[2]);
        end
        sb_cycle();
    endtask

    task automatic test_unmapped();
        bus.s_rsp_valid = 1'b1;
        bus.s_rsp_id    = 8'hA0;
        bus.s_rsp_last  = 1'b1;
        bus.m_rsp_ready = 4'b0000;
        #1;
        checks++;
        if (bus.s_rsp_ready !== 1'b1 || bus.m_rsp_valid !== 4'b0000 || bus.err_unmapped !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_sink: got ready=%b valid=%b err=%b want 1 0000 0",
                     bus.s_rsp_ready, bus.m_rsp_valid, bus.err_unmapped);
        end
        sb_cycle();
        clear_rsp();
        #1;
        checks++;
        if (bus.err_unmapped !== 1'b1 || dut.r_cnt[0] !== 8'd0 || dut.r_cnt[1] !== 8'd0 ||
            dut.r_cnt[2] !== 8'd1 || dut.r_cnt[3] !== 8'd0) begin
            errors++;
            $display("FAIL unmapped_pulse: got err=%b cnt=%0d,%0d,%0d,%0d want 1 0,0,1,0",
                     bus.err_unmapped, dut.r_cnt[0], dut.r_cnt[1], dut.r_cnt[2], dut.r_cnt[3]);
        end
        sb_cycle();
        #1;
        checks++;
        if (bus.err_unmapped !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_clear: got err=%b want 0", bus.err_unmapped);
        end
        sb_cycle();
    endtask

    task automatic test_same_cycle_and_reset();
        do_reset();
        set_req(4'b0010, 4'h3);
        bus.s_req_ready = 1'b1;
        sb_cycle();
        sb_cycle();
        bus.s_rsp_valid = 1'b1;
        bus.s_rsp_id    = 8'h47;
        bus.s_rsp_last  = 1'b1;
        bus.m_rsp_ready = 4'b0010;
        #1;
        checks++;
        if (bus.m_req_ready !== 4'b0010 || bus.s_rsp_ready !== 1'b1 || dut.r_cnt[1] !== 8'd2) begin
            errors++;
            $display("FAIL same_cycle_setup: got ready=%b s_rsp_ready=%b cnt=%0d want 0010 1 2",
                     bus.m_req_ready, bus.s_rsp_ready, dut.r_cnt[1]);
        end
        sb_cycle();
        bus.m_req_valid = '0;
        // last beat for master 0, whose count is already zero
        bus.s_rsp_id    = 8'h30;
        bus.m_rsp_ready = 4'b0001;
        #1;
        checks++;
        if (dut.r_cnt[1] !== 8'd2) begin
            errors++;
            $display("FAIL same_cycle_cnt: got %0d want 2", dut.r_cnt[1]);
        end
        sb_cycle();
        clear_rsp();
        #1;
        checks++;
        if (dut.r_cnt[0] !== 8'd0) begin
            errors++;
            $display("FAIL saturate_zero: got %0d want 0", dut.r_cnt[0]);
        end
        sb_cycle();
        set_req(4'hF, 4'h6);
        bus.s_req_ready = 1'b0;
        sb_cycle();
        bus.s_rsp_valid = 1'b1;
        bus.s_rsp_id    = 8'h41;
        bus.s_rsp_last  = 1'b0;
        bus.m_rsp_ready = 4'b0010;
        sb_cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.r_cnt[0] !== 8'd0 || dut.r_cnt[1] !== 8'd0 || dut.r_cnt[2] !== 8'd0 ||
            dut.r_cnt[3] !== 8'd0 || bus.s_req_valid !== 1'b0 || bus.idle !== 1'b1) begin
            errors++;
            $display("FAIL midburst_reset: got cnt=%0d,%0d,%0d,%0d v=%b idle=%b want 0,0,0,0 0 1",
                     dut.r_cnt[0], dut.r_cnt[1], dut.r_cnt[2], dut.r_cnt[3], bus.s_req_valid, bus.idle);
        end
        clear_inputs();
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_cycle();
        #1;
        checks++;
        if (bus.idle !== 1'b1 || bus.s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got idle=%b v=%b want 1 0", bus.idle, bus.s_req_valid);
        end
        sb_cycle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.m_req_addr = '0;
        clear_inputs();
        for (int i = 0; i < NMST; i++) begin
            gcount[i] = 0;
            maddr[i]  = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_throttle();
        test_backpressure();
        test_rsp_burst();
        test_unmapped();
        test_same_cycle_and_reset();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d requests never issued want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
